// File: rtl/mips_controller.sv
// MIPS main decoder and ALU decoder with a registered output stage.
// Every output is a flop, giving one cycle of latency from opcode/funct/zero.
module mips_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] funct,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [3:0] alucontrol,
  output logic       pcsrc,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrc,
  output logic       regwrite,
  output logic       memwrite,
  output logic       jump
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [3:0] alucontrol_d, alucontrol_q;
  logic       pcsrc_d, pcsrc_q;
  logic       regdst_d, regdst_q;
  logic       memtoreg_d, memtoreg_q;
  logic       alusrc_d, alusrc_q;
  logic       regwrite_d, regwrite_q;
  logic       memwrite_d, memwrite_q;
  logic       jump_d, jump_q;
  logic       branch_d;

  always_comb begin
    alucontrol_d = 4'b0000;
    regdst_d     = 1'b0;
    memtoreg_d   = 1'b0;
    alusrc_d     = 1'b0;
    regwrite_d   = 1'b0;
    memwrite_d   = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        // Unknown funct leaves everything at zero, so the instruction becomes a NOP.
        regwrite_d = 1'b1;
        regdst_d   = 1'b1;
        unique case (funct)
          FN_ADD:  alucontrol_d = ALU_ADD;
          FN_SUB:  alucontrol_d = ALU_SUB;
          FN_AND:  alucontrol_d = ALU_AND;
          FN_OR:   alucontrol_d = ALU_OR;
          FN_SLT:  alucontrol_d = ALU_SLT;
          default: begin
            regwrite_d = 1'b0;
            regdst_d   = 1'b0;
          end
        endcase
      end
      OP_LW: begin
        regwrite_d   = 1'b1;
        alusrc_d     = 1'b1;
        memtoreg_d   = 1'b1;
        alucontrol_d = ALU_ADD;
      end
      OP_SW: begin
        alusrc_d     = 1'b1;
        memwrite_d   = 1'b1;
        alucontrol_d = ALU_ADD;
      end
      OP_BEQ: begin
        branch_d     = 1'b1;
        alucontrol_d = ALU_SUB;
      end
      OP_ADDI: begin
        regwrite_d   = 1'b1;
        alusrc_d     = 1'b1;
        alucontrol_d = ALU_ADD;
      end
      OP_ORI: begin
        regwrite_d   = 1'b1;
        alusrc_d     = 1'b1;
        alucontrol_d = ALU_OR;
      end
      OP_SLTI: begin
        regwrite_d   = 1'b1;
        alusrc_d     = 1'b1;
        alucontrol_d = ALU_SLT;
      end
      OP_J: begin
        jump_d = 1'b1;
      end
      default: ;
    endcase
    pcsrc_d = branch_d & zero;
  end

  // Output register stage; reset clears every strobe and takes priority over decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      alucontrol_q <= 4'b0000;
      pcsrc_q      <= 1'b0;
      regdst_q     <= 1'b0;
      memtoreg_q   <= 1'b0;
      alusrc_q     <= 1'b0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      jump_q       <= 1'b0;
    end else begin
      alucontrol_q <= alucontrol_d;
      pcsrc_q      <= pcsrc_d;
      regdst_q     <= regdst_d;
      memtoreg_q   <= memtoreg_d;
      alusrc_q     <= alusrc_d;
      regwrite_q   <= regwrite_d;
      memwrite_q   <= memwrite_d;
      jump_q       <= jump_d;
    end
  end

  assign alucontrol = alucontrol_q;
  assign pcsrc      = pcsrc_q;
  assign regdst     = regdst_q;
  assign memtoreg   = memtoreg_q;
  assign alusrc     = alusrc_q;
  assign regwrite   = regwrite_q;
  assign memwrite   = memwrite_q;
  assign jump       = jump_q;

endmodule

// File: tb/tb_mips_controller.sv
// Bench for mips_controller: directed steps then random instructions, checked
// against a table-driven model of the instruction set.
module tb_mips_controller;

  logic       clk;
  logic       reset;
  logic [5:0] funct;
  logic [5:0] opcode;
  logic       zero;
  logic [3:0] alucontrol;
  logic       pcsrc, regdst, memtoreg, alusrc, regwrite, memwrite, jump;

  int checks   = 0;
  int failures = 0;

  mips_controller dut (
    .clk        (clk),
    .reset      (reset),
    .funct      (funct),
    .opcode     (opcode),
    .zero       (zero),
    .alucontrol (alucontrol),
    .pcsrc      (pcsrc),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrc     (alusrc),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .jump       (jump)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row layout: {alu[3:0], regwrite, regdst, alusrc, memtoreg, memwrite, branch, jump}
  logic [10:0] main_tbl [logic [5:0]];
  logic [3:0]  alu_tbl  [logic [5:0]];
  logic [5:0]  legal_ops [8];
  logic [5:0]  legal_fns [5];

  // Result layout: {alucontrol, pcsrc, regdst, memtoreg, alusrc, regwrite, memwrite, jump}
  function automatic logic [10:0] model(input logic rst, input logic [5:0] op,
                                        input logic [5:0] fn, input logic z);
    logic [10:0] row;
    row = 11'b0;
    if (!rst && main_tbl.exists(op)) begin
      row = main_tbl[op];
      if (op == 6'b000000) begin
        if (alu_tbl.exists(fn)) row[10:7] = alu_tbl[fn];
        else row = 11'b0;
      end
    end
    return {row[10:7], row[1] & z, row[5], row[3], row[4], row[6], row[2], row[0]};
  endfunction

  function automatic logic [10:0] observed();
    return {alucontrol, pcsrc, regdst, memtoreg, alusrc, regwrite, memwrite, jump};
  endfunction

  task automatic check(input string tag, input logic [10:0] exp);
    logic [10:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, check 1 time unit after the following rising edge.
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn, input logic z);
    @(negedge clk);
    reset  = rst;
    opcode = op;
    funct  = fn;
    zero   = z;
    @(posedge clk);
    #1;
    check(tag, model(rst, op, fn, z));
  endtask

  initial begin
    main_tbl[6'b000000] = {4'b0000, 7'b1100000};
    main_tbl[6'b100011] = {4'b0010, 7'b1011000};
    main_tbl[6'b101011] = {4'b0010, 7'b0010100};
    main_tbl[6'b000100] = {4'b0110, 7'b0000010};
    main_tbl[6'b001000] = {4'b0010, 7'b1010000};
    main_tbl[6'b001101] = {4'b0001, 7'b1010000};
    main_tbl[6'b001010] = {4'b0111, 7'b1010000};
    main_tbl[6'b000010] = {4'b0000, 7'b0000001};
    alu_tbl[6'b100000] = 4'b0010;
    alu_tbl[6'b100010] = 4'b0110;
    alu_tbl[6'b100100] = 4'b0000;
    alu_tbl[6'b100101] = 4'b0001;
    alu_tbl[6'b101010] = 4'b0111;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                  6'b001000, 6'b001101, 6'b001010, 6'b000010};
    legal_fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    reset = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0;

    step("reset_lw", 1'b1, 6'b100011, 6'b0, 1'b0);
    check("reset_hard_zero", 11'b0);
    step("lw_after_reset", 1'b0, 6'b100011, 6'b0, 1'b0);
    check("lw_hard", {4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});

    step("r_add", 1'b0, 6'b000000, 6'b100000, 1'b0);
    check("r_add_hard", {4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    step("r_sub", 1'b0, 6'b000000, 6'b100010, 1'b1);
    step("r_and", 1'b0, 6'b000000, 6'b100100, 1'b0);
    step("r_or",  1'b0, 6'b000000, 6'b100101, 1'b0);
    step("r_slt", 1'b0, 6'b000000, 6'b101010, 1'b0);
    check("r_slt_hard", {4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    step("r_bad_funct", 1'b0, 6'b000000, 6'b111111, 1'b1);
    check("r_bad_funct_hard", 11'b0);

    step("sw", 1'b0, 6'b101011, 6'b100000, 1'b0);
    check("sw_hard", {4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});

    step("beq_taken", 1'b0, 6'b000100, 6'b0, 1'b1);
    check("beq_taken_hard", {4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    step("beq_not_taken", 1'b0, 6'b000100, 6'b0, 1'b0);
    step("addi_zero_set", 1'b0, 6'b001000, 6'b100010, 1'b1);
    check("addi_hard", {4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    step("ori",  1'b0, 6'b001101, 6'b0, 1'b0);
    step("slti", 1'b0, 6'b001010, 6'b0, 1'b0);
    step("jump", 1'b0, 6'b000010, 6'b101010, 1'b1);
    check("jump_hard", {4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    step("bad_opcode", 1'b0, 6'b111111, 6'b100000, 1'b1);

    // Inputs changing mid-cycle must not reach the outputs before the next edge.
    step("latency_addi", 1'b0, 6'b001000, 6'b0, 1'b0);
    #2 opcode = 6'b101011;
    @(negedge clk);
    check("latency_hold_addi", model(1'b0, 6'b001000, 6'b0, 1'b0));
    @(posedge clk);
    #1;
    check("latency_switch_sw", model(1'b0, 6'b101011, 6'b0, 1'b0));

    step("midstream_lw", 1'b0, 6'b100011, 6'b0, 1'b0);
    step("midstream_reset", 1'b1, 6'b000100, 6'b0, 1'b1);
    step("resume_beq", 1'b0, 6'b000100, 6'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] op, fn;
      logic       z, rst;
      op  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
      fn  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fns[$urandom_range(0, 4)];
      z   = 1'($urandom);
      rst = ($urandom_range(0, 15) == 0);
      step("random", rst, op, fn, z);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
